// File: rtl/ppg_pkg.sv
// Shared types and default widths for the PPG beat-detection datapath.
package ppg_pkg;

  localparam int DATA_W = 20;
  localparam int CNT_W  = 12;

  typedef enum logic [1:0] {
    SEARCH,
    TRACK,
    REFRACTORY
  } pd_state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; a synchronous load overrides counting.
module sat_counter #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/peak_detector.sv
// Adaptive-threshold peak detector: tracks each excursion above thr, confirms
// the peak when the signal falls back, and reports the peak-to-peak interval.
module peak_detector #(
  parameter int DATA_W  = ppg_pkg::DATA_W,
  parameter int CNT_W   = ppg_pkg::CNT_W,
  parameter int MIN_THR = 200,
  parameter int REFRACT = 15,
  parameter int TIMEOUT = 400
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_valid,
  input  logic signed [DATA_W-1:0] sample_in,
  output logic                     beat_valid,
  output logic        [CNT_W-1:0]  beat_interval,
  output logic signed [DATA_W-1:0] peak_amp,
  output logic                     lost
);

  import ppg_pkg::*;

  localparam logic signed [DATA_W-1:0] MIN_THR_C = DATA_W'(MIN_THR);
  localparam logic        [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic        [CNT_W-1:0]  REFR_LAST = CNT_W'(REFRACT - 1);

  pd_state_e                state;
  logic signed [DATA_W-1:0] thr;
  logic signed [DATA_W-1:0] max_amp;
  logic signed [DATA_W-1:0] half_amp;
  logic signed [DATA_W-1:0] new_thr;
  logic        [CNT_W-1:0]  icnt;
  logic        [CNT_W-1:0]  icnt_plus1;
  logic        [CNT_W-1:0]  max_cnt;
  logic        [CNT_W-1:0]  refr_cnt;
  logic        [CNT_W-1:0]  cnt_load_val;
  logic                     have_prev;
  logic                     above_thr;
  logic                     timeout;
  logic                     confirm;
  logic                     cnt_load;

  always_comb begin
    above_thr    = sample_in > thr;
    timeout      = sample_valid && (icnt >= TIMEOUT_C);
    confirm      = sample_valid && (state == TRACK) && !above_thr && !timeout;
    icnt_plus1   = (&icnt) ? icnt : icnt + 1'b1;
    half_amp     = max_amp >>> 1;
    new_thr      = (half_amp > MIN_THR_C) ? half_amp : MIN_THR_C;
    cnt_load     = timeout || confirm;
    // Re-base the interval counter so it counts from the peak sample, not the confirm.
    cnt_load_val = timeout ? '0 : icnt_plus1 - max_cnt;
  end

  sat_counter #(.W(CNT_W)) u_icnt (
    .clk      (clk),
    .rst      (rst),
    .inc      (sample_valid),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .cnt      (icnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= SEARCH;
      thr           <= MIN_THR_C;
      have_prev     <= 1'b0;
      max_amp       <= '0;
      max_cnt       <= '0;
      refr_cnt      <= '0;
      beat_valid    <= 1'b0;
      lost          <= 1'b0;
      beat_interval <= '0;
      peak_amp      <= '0;
    end else begin
      beat_valid <= 1'b0;
      lost       <= 1'b0;
      if (timeout) begin
        lost      <= 1'b1;
        thr       <= MIN_THR_C;
        have_prev <= 1'b0;
        refr_cnt  <= '0;
        state     <= SEARCH;
      end else if (sample_valid) begin
        case (state)
          SEARCH: begin
            if (above_thr) begin
              state   <= TRACK;
              max_amp <= sample_in;
              max_cnt <= icnt;
            end
          end
          TRACK: begin
            if (!above_thr) begin
              peak_amp <= max_amp;
              thr      <= new_thr;
              refr_cnt <= '0;
              state    <= REFRACTORY;
              if (have_prev) begin
                beat_interval <= max_cnt;
                beat_valid    <= 1'b1;
              end else begin
                have_prev <= 1'b1;
              end
            end else if (sample_in > max_amp) begin
              max_amp <= sample_in;
              max_cnt <= icnt;
            end
          end
          REFRACTORY: begin
            if (refr_cnt >= REFR_LAST) begin
              refr_cnt <= '0;
              state    <= SEARCH;
            end else begin
              refr_cnt <= refr_cnt + 1'b1;
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_peak_detector.sv
// Directed bench for peak_detector: table of pulse-train segments plus reset sequences.
module tb_peak_detector;

  localparam int DW = 20;
  localparam int CW = 12;

  logic                 clk = 1'b0;
  logic                 clk_en = 1'b0;
  logic                 rst = 1'b1;
  logic                 sample_valid = 1'b0;
  logic signed [DW-1:0] sample_in = '0;
  logic                 beat_valid;
  logic        [CW-1:0] beat_interval;
  logic signed [DW-1:0] peak_amp;
  logic                 lost;

  int n_checks = 0;
  int n_err    = 0;
  int bv_cnt   = 0;
  int lost_cnt = 0;
  int stray    = 0;

  typedef struct {
    int amp;
    int plateau;
    int gap;
    int bump_idx;
    int bump_val;
    int exp_bv;
    int exp_int;
    int exp_peak;
    int exp_thr;
    int exp_lost;
  } vec_t;

  vec_t vecs[11];

  peak_detector #(
    .DATA_W  (DW),
    .CNT_W   (CW),
    .MIN_THR (200),
    .REFRACT (15),
    .TIMEOUT (400)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .sample_valid  (sample_valid),
    .sample_in     (sample_in),
    .beat_valid    (beat_valid),
    .beat_interval (beat_interval),
    .peak_amp      (peak_amp),
    .lost          (lost)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge: one valid cycle, then one invalid cycle carrying junk.
  task automatic send(input int v);
    sample_in    = DW'(v);
    sample_valid = 1'b1;
    @(negedge clk);
    bv_cnt   += int'(beat_valid);
    lost_cnt += int'(lost);
    sample_valid = 1'b0;
    sample_in    = DW'(90000);
    @(negedge clk);
    stray += int'(beat_valid) + int'(lost);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_beat_valid"}, int'(beat_valid), 0);
    chk({tag, "_lost"}, int'(lost), 0);
    chk({tag, "_interval"}, int'(beat_interval), 0);
    chk({tag, "_peak_amp"}, int'(peak_amp), 0);
    chk({tag, "_thr"}, int'(dut.thr), 200);
    chk({tag, "_state"}, int'(dut.state), int'(ppg_pkg::SEARCH));
  endtask

  initial begin
    //          amp  plat gap  bump_i bump_v  bv  int  peak  thr lost
    vecs[0]  = '{1000, 1,  59,  -1,    0,     0,   0, 1000, 500, 0};
    vecs[1]  = '{1000, 1,  59,  -1,    0,     1,  60, 1000, 500, 0};
    vecs[2]  = '{1000, 1,  59,  -1,    0,     1,  60, 1000, 500, 0};
    vecs[3]  = '{ 800, 3,  57,  -1,    0,     1,  60,  800, 400, 0};
    vecs[4]  = '{1000, 1,  59,  -1,    0,     1,  60, 1000, 500, 0};
    vecs[5]  = '{1000, 1,  59,  16,  900,     1,  60, 1000, 500, 0};
    vecs[6]  = '{1000, 1, 397,  -1,    0,     1,  60, 1000, 500, 0};
    vecs[7]  = '{1000, 1, 400,  -1,    0,     1, 398, 1000, 200, 1};
    vecs[8]  = '{1000, 1,  59,  -1,    0,     0, 398, 1000, 500, 0};
    vecs[9]  = '{1000, 1,  59,  -1,    0,     1,  60, 1000, 500, 0};
    vecs[10] = '{1000, 1, 400, 399,  700,     1,  60, 1000, 200, 1};

    // Reset with the clock stopped must clear everything at once.
    #3 rst = 1'b0;
    #1 chk_reset_vals("rst_noclk");

    clk_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    for (int r = 0; r < 11; r++) begin
      bv_cnt   = 0;
      lost_cnt = 0;
      for (int i = 0; i < vecs[r].plateau; i++) send(vecs[r].amp);
      for (int i = 0; i < vecs[r].gap; i++)
        send((vecs[r].plateau + i == vecs[r].bump_idx) ? vecs[r].bump_val : 0);
      chk($sformatf("r%0d_beats", r), bv_cnt, vecs[r].exp_bv);
      chk($sformatf("r%0d_interval", r), int'(beat_interval), vecs[r].exp_int);
      chk($sformatf("r%0d_peak_amp", r), int'(peak_amp), vecs[r].exp_peak);
      chk($sformatf("r%0d_thr", r), int'(dut.thr), vecs[r].exp_thr);
      chk($sformatf("r%0d_lost", r), lost_cnt, vecs[r].exp_lost);
    end

    // Reset in the middle of a tracked peak; the interrupted peak is discarded.
    bv_cnt = 0;
    send(1000);
    chk("mid_track_state", int'(dut.state), int'(ppg_pkg::TRACK));
    rst = 1'b0;
    #1 chk_reset_vals("rst_track");
    @(negedge clk);
    rst = 1'b1;
    send(0);
    send(1000);
    for (int i = 0; i < 59; i++) send(0);
    chk("post_rst_first_beats", bv_cnt, 0);
    chk("post_rst_first_peak", int'(peak_amp), 1000);
    chk("post_rst_first_thr", int'(dut.thr), 500);
    send(1000);
    for (int i = 0; i < 59; i++) send(0);
    chk("post_rst_second_beats", bv_cnt, 1);
    chk("post_rst_second_interval", int'(beat_interval), 60);
    chk("pulse_width_one_clk", stray, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
